sr_cmd_arbiter: RTL

SR_CMD_ARBITER -- requirements
Module: sr_cmd_arbiter

---
 rtl/sr_cmd_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sr_cmd_arbiter.sv
// Two-requester round-robin arbiter that pulses the S or R input of one SR latch
// cell, waits a settle cycle, then checks the latch readback and counts mismatches.
module sr_cmd_arbiter #(
    parameter int  N_BITS       = 4,
    parameter int  PULSE_CYCLES = 2,
    localparam int IW           = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              cmd_a,
    input  logic [IW-1:0]     idx_a,
    input  logic              req_b,
    input  logic              cmd_b,
    input  logic [IW-1:0]     idx_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic [N_BITS-1:0] S,
    output logic [N_BITS-1:0] R,
    input  logic [N_BITS-1:0] Q_fb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        fail_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt, w_cnt_next;
    logic              r_cmd, w_cmd_next;
    logic [IW-1:0]     r_idx, w_idx_next;
    logic              r_last_b, w_last_b_next;
    logic              r_gnt_a, w_gnt_a_next;
    logic              r_gnt_b, w_gnt_b_next;
    logic [N_BITS-1:0] r_s, w_s_next;
    logic [N_BITS-1:0] r_r, w_r_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;
    logic [7:0]        r_fail_cnt, w_fail_cnt_next;

    logic              w_any_req;
    logic              w_pick_b;
    logic              w_sel_cmd;
    logic [IW-1:0]     w_sel_idx;
    logic [N_BITS-1:0] w_sel_dec;

    // B wins only when A is absent or when A took the previous grant.
    assign w_any_req = req_a | req_b;
    assign w_pick_b  = req_b & (~req_a | ~r_last_b);
    assign w_sel_cmd = w_pick_b ? cmd_b : cmd_a;
    assign w_sel_idx = w_pick_b ? idx_b : idx_a;

    generate
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_dec
            assign w_sel_dec[gi] = (w_sel_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_cmd_next      = r_cmd;
        w_idx_next      = r_idx;
        w_last_b_next   = r_last_b;
        w_gnt_a_next    = 1'b0;
        w_gnt_b_next    = 1'b0;
        w_s_next        = r_s;
        w_r_next        = r_r;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;
        w_fail_cnt_next = r_fail_cnt;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next  = DRIVE;
                    w_gnt_a_next  = ~w_pick_b;
                    w_gnt_b_next  = w_pick_b;
                    w_last_b_next = w_pick_b;
                    w_cmd_next    = w_sel_cmd;
                    w_idx_next    = w_sel_idx;
                    w_cnt_next    = 4'(PULSE_CYCLES - 1);
                    w_s_next      = w_sel_cmd ? w_sel_dec : '0;
                    w_r_next      = w_sel_cmd ? '0 : w_sel_dec;
                end
            end
            DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = SETTLE;
                    w_s_next     = '0;
                    w_r_next     = '0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            SETTLE: begin
                w_state_next = CHECK;
            end
            CHECK: begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
                w_err_next   = (Q_fb[r_idx] != r_cmd);
                if (w_err_next && (r_fail_cnt != 8'hFF)) begin
                    w_fail_cnt_next = r_fail_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_s_next     = '0;
                w_r_next     = '0;
            end
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_cmd      <= 1'b0;
            r_idx      <= '0;
            r_last_b   <= 1'b1;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_s        <= '0;
            r_r        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_fail_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cmd      <= w_cmd_next;
            r_idx      <= w_idx_next;
            r_last_b   <= w_last_b_next;
            r_gnt_a    <= w_gnt_a_next;
            r_gnt_b    <= w_gnt_b_next;
            r_s        <= w_s_next;
            r_r        <= w_r_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_fail_cnt <= w_fail_cnt_next;
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign S        = r_s;
    assign R        = r_r;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign fail_cnt = r_fail_cnt;

endmodule
